pipe_skid_reg: RTL
==================

# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the generalised successor of the fixed per-signal stage registers between pipeline stages: one instance carries an arbitrary-width data payload plus a control sub-field. The control sub-field is forced to zero whenever the stage holds a bubble. Backpressure replaces the global enable, and `in_ready` is registered, so there is no combinational path from `out_ready` to `in_ready`. This breaks stall-signal timing chains across the core.

## Interface
Parameters:
- `DATA_W`, 16: payload width (rd1/rd2/pcinc-class data), must be ≥1
- `CTRL_W`, 8: control sub-field width (regwrite, mem-write, halt-class bits); zeroed on bubble, must be ≥1
- `CNT_W`, 16: stall counter width (used only with `PIPE_STALL_CNT_EN`)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous active-low reset (0 = reset asserted)
- `flush`  in  1  synchronous flush; discards all held entries
- `in_valid`  in  1  upstream offers an entry
- `in_ready`  out  1  stage can accept; registered
- `in_data`  in  `DATA_W`  upstream payload
- `in_ctrl`  in  `CTRL_W`  upstream control bits
- `out_valid`  out  1  stage holds a valid entry
- `out_ready`  in  1  downstream accepts
- `out_data`  out  `DATA_W`  payload of head entry
- `out_ctrl`  out  `CTRL_W`  control bits of head entry; 0 when `out_valid`=0
- `stall_cnt`  out  `CNT_W`  only present with `PIPE_STALL_CNT_EN`

## Operation
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Storage is a main register (drives outputs) plus one skid register.
- States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
- EMPTY: push → ONE, main ← input.
- ONE:
  - push & pop → ONE, main ← input.
  - push & !pop → FULL, skid ← input.
  - pop & !push → EMPTY.
  - neither → hold.
- FULL: `in_ready`=0, so no push. Pop → ONE, main ← skid. No pop → hold.
- `in_ready` = 1 in EMPTY/ONE, 0 in FULL. It is computed from the next state and registered.
- `out_valid` = 1 in ONE/FULL.
- `out_ctrl` is gated to 0 when `out_valid`=0. `out_data` holds its last loaded value when invalid.
- Flush has priority over push and pop:
  - Next state is EMPTY and main/skid ctrl are cleared.
  - Any push in the flush cycle is discarded.
  - A pop in the flush cycle completes normally for downstream; the entry was presented and is consumed.
- Ordering: entries leave in arrival order. No entry is dropped or duplicated except by flush.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state EMPTY
  - `out_valid`=0, `out_data`=0, `out_ctrl`=0
  - `in_ready`=1
  - `stall_cnt`=0
- Reset mid-operation discards all entries immediately. Outputs take reset values without waiting for a clock edge.
- Latency: an entry pushed at edge N appears on `out_*` after edge N (1 cycle) when the stage is EMPTY or popping.
- Throughput: 1 entry/cycle sustained with `out_ready`=1.
- After `out_ready` drops, `in_ready` falls 1 cycle later. The skid absorbs the one in-flight entry.
- After a pop from FULL, `in_ready` rises at the following edge.
- After flush at edge N: `out_valid`=0 and `in_ready`=1 from edge N.

## Configuration
- `PIPE_STALL_CNT_EN` defined:
  - Adds port `stall_cnt` and its counter.
  - Increments once per cycle where `out_valid & !out_ready`.
  - Saturates at 2^`CNT_W`−1, so it never wraps.
  - Not cleared by flush; cleared only by reset.
- Not defined: port and counter are absent. Handshake behaviour is identical.

## Test plan
- Reset then single push: assert `reset`=0, then release. Push `in_data`=16'h1234, `in_ctrl`=8'h05 → next cycle `out_valid`=1, `out_data`=16'h1234, `out_ctrl`=8'h05; `in_ready` stays 1.
- Streaming: push 0..15 back-to-back with `out_ready`=1 → outputs 0..15 in order, one per cycle, `in_ready` never 0.
- Backpressure/skid: stream 0,1,2,… and drop `out_ready` for 3 cycles, then restore.
  - Stage goes FULL holding 2 entries, and `in_ready`=0 one cycle after the drop.
  - After restore, no loss and no duplication.
  - With `PIPE_STALL_CNT_EN`: `stall_cnt`=3.
- Flush while FULL with a simultaneous push of 16'hBEEF → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1. 16'hBEEF never appears on the output.
- Async reset mid-stream: pull `reset` low between edges while FULL → `out_valid`=0, `in_ready`=1 immediately (before the next edge), and `stall_cnt`=0.
- Saturation (`CNT_W`=4, `PIPE_STALL_CNT_EN`): hold a valid entry with `out_ready`=0 for 20 cycles → `stall_cnt`=15 and held.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with a two-entry skid buffer and registered in_ready.
// Optional stall counter port is enabled by defining PIPE_STALL_CNT_EN.
`default_nettype none

module pipe_skid_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  if (DATA_W < 1) begin : g_chk_data_w
    $error("pipe_skid_reg: DATA_W must be >= 1");
  end
  if (CTRL_W < 1) begin : g_chk_ctrl_w
    $error("pipe_skid_reg: CTRL_W must be >= 1");
  end
  if (CNT_W < 1) begin : g_chk_cnt_w
    $error("pipe_skid_reg: CNT_W must be >= 1");
  end

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  logic w_push, w_pop;
  logic w_load_main_in, w_load_main_skid, w_load_skid;

  assign w_push = in_valid & in_ready_q;
  assign w_pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic; flush overrides any push/pop transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (w_push) state_d = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      state_d = S_FULL;
        else if (w_pop && !w_push) state_d = S_EMPTY;
      end
      S_FULL:  if (w_pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Outputs; in_ready is derived from the next state so it can be registered
  always_comb begin
    out_valid  = (state_q != S_EMPTY);
    in_ready_d = (state_d != S_FULL);
    out_ctrl   = out_valid ? main_ctrl_q : '0;
  end

  assign in_ready = in_ready_q;
  assign out_data = main_data_q;

  assign w_load_main_in   = !flush && w_push &&
                            ((state_q == S_EMPTY) || ((state_q == S_ONE) && w_pop));
  assign w_load_skid      = !flush && w_push && (state_q == S_ONE) && !w_pop;
  assign w_load_main_skid = !flush && w_pop && (state_q == S_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
    end else if (w_load_main_in) begin
      main_data_q <= in_data;
      main_ctrl_q <= in_ctrl;
    end else if (w_load_main_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      skid_ctrl_q <= '0;
    end else if (w_load_skid) begin
      skid_data_q <= in_data;
      skid_ctrl_q <= in_ctrl;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating; survives flush, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
